// File: rtl/ace_instbuf.sv
// ace_instbuf: instruction buffer between fetch and decode.
//
// A circular FIFO of DEPTH 32-bit entries. Each cycle it accepts up to eight
// fetched instructions and presents up to four of the oldest ones, in program
// order, to the decode slots.
//
// Enqueue: the valid fetch lanes may be non-contiguous. They are packed in
// lane order into consecutive slots starting at the tail.
// Dequeue: decode consumes up to four entries from the head.
// The retire flush empties the buffer. It does not clear the storage.
//
// Ports:
//   clock, reset_n              core clock, asynchronous active-low reset
//   retire_flush_i              empties the buffer at the next edge
//   fetch_inst0..7_i / _vld_i   fetch group, lane 0 oldest, per-lane valid
//   deq_cnt_i                   entries decode consumes (values above 4 mean 4)
//   inst0..3_o / _vld_o         head entries, inst0_o oldest
//   instbuf_full_o              fewer than 8 free entries (fetch back-pressure)
//   instbuf_empty_o             buffer holds nothing
//   count_o                     current occupancy
//
// Optional build macro ACE_INSTBUF_OVF_EN adds two outputs:
//   ovf_o       sticky flag: fetch presented valid lanes while the buffer was full
//   drop_cnt_o  saturating count of dropped instructions
// All outputs are driven from registered state only.
module ace_instbuf #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             retire_flush_i,
  input  logic [31:0]      fetch_inst0_i,
  input  logic [31:0]      fetch_inst1_i,
  input  logic [31:0]      fetch_inst2_i,
  input  logic [31:0]      fetch_inst3_i,
  input  logic [31:0]      fetch_inst4_i,
  input  logic [31:0]      fetch_inst5_i,
  input  logic [31:0]      fetch_inst6_i,
  input  logic [31:0]      fetch_inst7_i,
  input  logic             fetch_inst0_vld_i,
  input  logic             fetch_inst1_vld_i,
  input  logic             fetch_inst2_vld_i,
  input  logic             fetch_inst3_vld_i,
  input  logic             fetch_inst4_vld_i,
  input  logic             fetch_inst5_vld_i,
  input  logic             fetch_inst6_vld_i,
  input  logic             fetch_inst7_vld_i,
  input  logic [2:0]       deq_cnt_i,
  output logic [31:0]      inst0_o,
  output logic [31:0]      inst1_o,
  output logic [31:0]      inst2_o,
  output logic [31:0]      inst3_o,
  output logic             inst0_vld_o,
  output logic             inst1_vld_o,
  output logic             inst2_vld_o,
  output logic             inst3_vld_o,
  output logic             instbuf_full_o,
  output logic             instbuf_empty_o,
  output logic [PTR_W:0]   count_o
`ifdef ACE_INSTBUF_OVF_EN
  ,
  output logic             ovf_o,
  output logic [15:0]      drop_cnt_o
`endif
);

  // Full threshold: once occupancy exceeds this value, eight free slots are
  // no longer guaranteed.
  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 8);

  // Number of set bits in a lane-valid vector.
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'd0, v[i]};
    end
    return acc;
  endfunction

  logic [31:0]      storage_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic [31:0]      lane_inst_s [8];
  logic [7:0]       lane_vld_s;
  logic [2:0]       lane_off_s [8];
  logic [3:0]       enq_acc_s;
  logic [3:0]       n_valid_s;
  logic [3:0]       n_enq_s;
  logic [2:0]       deq_lim_s;
  logic [2:0]       n_deq_s;
  logic             full_s;
  logic             enq_en_s;

  assign lane_inst_s[0] = fetch_inst0_i;
  assign lane_inst_s[1] = fetch_inst1_i;
  assign lane_inst_s[2] = fetch_inst2_i;
  assign lane_inst_s[3] = fetch_inst3_i;
  assign lane_inst_s[4] = fetch_inst4_i;
  assign lane_inst_s[5] = fetch_inst5_i;
  assign lane_inst_s[6] = fetch_inst6_i;
  assign lane_inst_s[7] = fetch_inst7_i;
  assign lane_vld_s = {fetch_inst7_vld_i, fetch_inst6_vld_i, fetch_inst5_vld_i,
                       fetch_inst4_vld_i, fetch_inst3_vld_i, fetch_inst2_vld_i,
                       fetch_inst1_vld_i, fetch_inst0_vld_i};

  assign full_s    = (count_r > FULL_THR);
  assign enq_en_s  = !full_s && !retire_flush_i;
  assign n_valid_s = popcnt8(lane_vld_s);

  // Lane compaction: each lane's slot offset is the number of valid lanes below it.
  always_comb begin
    enq_acc_s = 4'd0;
    for (int j = 0; j < 8; j++) begin
      lane_off_s[j] = enq_acc_s[2:0];
      enq_acc_s     = enq_acc_s + {3'd0, lane_vld_s[j]};
    end
  end

  // Enqueue and dequeue amounts. Dequeue is clamped to 4 and to the occupancy.
  always_comb begin
    n_enq_s   = 4'd0;
    deq_lim_s = deq_cnt_i;
    n_deq_s   = 3'd0;
    if (enq_en_s) begin
      n_enq_s = enq_acc_s;
    end else begin
      n_enq_s = 4'd0;
    end
    if (deq_cnt_i > 3'd4) begin
      deq_lim_s = 3'd4;
    end else begin
      deq_lim_s = deq_cnt_i;
    end
    if (count_r < (PTR_W+1)'(deq_lim_s)) begin
      n_deq_s = count_r[2:0];
    end else begin
      n_deq_s = deq_lim_s;
    end
  end

  // Storage write: valid lanes land in consecutive slots from the tail.
  // Indices wrap naturally, so a group may straddle the end of the array.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_r[i] <= 32'd0;
      end
    end else if (enq_en_s) begin
      for (int j = 0; j < 8; j++) begin
        if (lane_vld_s[j]) begin
          storage_r[tail_r + PTR_W'(lane_off_s[j])] <= lane_inst_s[j];
        end
      end
    end
  end

  // Pointer and occupancy update. Flush wins over a same-cycle enqueue or dequeue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (retire_flush_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(n_deq_s);
      tail_r  <= tail_r + PTR_W'(n_enq_s);
      count_r <= count_r + (PTR_W+1)'(n_enq_s) - (PTR_W+1)'(n_deq_s);
    end
  end

  assign inst0_o         = storage_r[head_r];
  assign inst1_o         = storage_r[head_r + PTR_W'(1)];
  assign inst2_o         = storage_r[head_r + PTR_W'(2)];
  assign inst3_o         = storage_r[head_r + PTR_W'(3)];
  assign inst0_vld_o     = (count_r > (PTR_W+1)'(0));
  assign inst1_vld_o     = (count_r > (PTR_W+1)'(1));
  assign inst2_vld_o     = (count_r > (PTR_W+1)'(2));
  assign inst3_vld_o     = (count_r > (PTR_W+1)'(3));
  assign instbuf_full_o  = full_s;
  assign instbuf_empty_o = (count_r == '0);
  assign count_o         = count_r;

`ifdef ACE_INSTBUF_OVF_EN
  logic        ovf_r;
  logic [15:0] drop_cnt_r;
  logic        drop_s;
  logic [16:0] drop_sum_s;

  assign drop_s     = full_s && !retire_flush_i && (lane_vld_s != 8'd0);
  assign drop_sum_s = {1'b0, drop_cnt_r} + {13'd0, n_valid_s};

  // Sticky overflow flag: set on a dropped group, cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
    end else if (retire_flush_i) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Saturating count of dropped instructions. Only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  assign ovf_o      = ovf_r;
  assign drop_cnt_o = drop_cnt_r;
`else
  // Without the overflow feature, groups offered while full are dropped silently.
  logic unused_valid_cnt_s;
  assign unused_valid_cnt_s = ^n_valid_s;
`endif

endmodule

// File: tb/tb_ace_instbuf.sv
// Self-checking bench for ace_instbuf. The buffer is modelled as a queue of
// instructions in program order, driven by directed and random stimulus.
module tb_ace_instbuf;
  localparam int DEPTH = 16;

  logic        clock;
  logic        reset_n;
  logic        retire_flush;
  logic [31:0] lane_inst [8];
  logic [7:0]  lane_vld;
  logic [2:0]  deq_cnt;
  logic [31:0] inst_out [4];
  logic [3:0]  inst_vld;
  logic        full;
  logic        empty;
  logic [4:0]  count;
`ifdef ACE_INSTBUF_OVF_EN
  logic        ovf;
  logic [15:0] drop_cnt;
`endif

  ace_instbuf #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .retire_flush_i(retire_flush),
    .fetch_inst0_i(lane_inst[0]), .fetch_inst1_i(lane_inst[1]),
    .fetch_inst2_i(lane_inst[2]), .fetch_inst3_i(lane_inst[3]),
    .fetch_inst4_i(lane_inst[4]), .fetch_inst5_i(lane_inst[5]),
    .fetch_inst6_i(lane_inst[6]), .fetch_inst7_i(lane_inst[7]),
    .fetch_inst0_vld_i(lane_vld[0]), .fetch_inst1_vld_i(lane_vld[1]),
    .fetch_inst2_vld_i(lane_vld[2]), .fetch_inst3_vld_i(lane_vld[3]),
    .fetch_inst4_vld_i(lane_vld[4]), .fetch_inst5_vld_i(lane_vld[5]),
    .fetch_inst6_vld_i(lane_vld[6]), .fetch_inst7_vld_i(lane_vld[7]),
    .deq_cnt_i(deq_cnt),
    .inst0_o(inst_out[0]), .inst1_o(inst_out[1]),
    .inst2_o(inst_out[2]), .inst3_o(inst_out[3]),
    .inst0_vld_o(inst_vld[0]), .inst1_vld_o(inst_vld[1]),
    .inst2_vld_o(inst_vld[2]), .inst3_vld_o(inst_vld[3]),
    .instbuf_full_o(full), .instbuf_empty_o(empty), .count_o(count)
`ifdef ACE_INSTBUF_OVF_EN
    , .ovf_o(ovf), .drop_cnt_o(drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: queued instructions (oldest first), overflow flag, drop count.
  int unsigned model_q [$];
  bit          model_ovf;
  int          model_drop;
  int          n_vec;
  int          n_miss;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_outputs(input string tag);
    int sz;
    sz = model_q.size();
    check_value({tag, "_count"}, 32'(count), 32'(sz));
    check_value({tag, "_empty"}, 32'(empty), 32'(sz == 0));
    check_value({tag, "_full"},  32'(full),  32'(sz > DEPTH - 8));
    for (int k = 0; k < 4; k++) begin
      check_value($sformatf("%s_vld%0d", tag, k), 32'(inst_vld[k]), 32'(sz > k));
      if (sz > k) check_value($sformatf("%s_inst%0d", tag, k), inst_out[k], model_q[k]);
    end
`ifdef ACE_INSTBUF_OVF_EN
    check_value({tag, "_ovf"},  32'(ovf), 32'(model_ovf));
    check_value({tag, "_drop"}, 32'(drop_cnt), 32'(model_drop));
`endif
  endtask

  // Apply one cycle of stimulus. Called and returns at a negative edge.
  task automatic step(input string tag, input logic [7:0] vld, input logic [31:0] base,
                      input logic [2:0] deq, input logic flush);
    bit was_full;
    int n_deq;
    int n_valid;
    lane_vld     = vld;
    deq_cnt      = deq;
    retire_flush = flush;
    for (int k = 0; k < 8; k++) lane_inst[k] = base + 32'(k);
    was_full = model_q.size() > DEPTH - 8;
    n_valid  = $countones(vld);
    if (flush) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      n_deq = (deq > 4) ? 4 : int'(deq);
      if (n_deq > model_q.size()) n_deq = model_q.size();
      repeat (n_deq) void'(model_q.pop_front());
      if (!was_full) begin
        for (int k = 0; k < 8; k++) if (vld[k]) model_q.push_back(base + 32'(k));
      end else if (n_valid != 0) begin
        model_ovf  = 1'b1;
        model_drop = (model_drop + n_valid > 65535) ? 65535 : model_drop + n_valid;
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs(tag);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; model_ovf = 1'b0; model_drop = 0;
    clock = 1'b0; reset_n = 1'b0; retire_flush = 1'b0; lane_vld = 8'd0; deq_cnt = 3'd0;
    for (int k = 0; k < 8; k++) lane_inst[k] = 32'd0;
    @(negedge clock);
    check_outputs("reset");
    for (int k = 0; k < 4; k++) check_value($sformatf("reset_inst%0d", k), inst_out[k], 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // First fill: eight lanes; the buffer reaches exactly the full threshold without being full.
    step("tp1", 8'hFF, 32'h100, 3'd0, 1'b0);
    check_value("tp1_cnt8", 32'(count), 32'd8);
    check_value("tp1_i0", inst_out[0], 32'h100);
    check_value("tp1_i3", inst_out[3], 32'h103);
    check_value("tp1_full", 32'(full), 32'd0);

    // Non-contiguous lane mask gets compacted.
    step("fl1", 8'h00, 32'h0, 3'd0, 1'b1);
    step("tp2", 8'b1010_0101, 32'h200, 3'd0, 1'b0);
    check_value("tp2_i1", inst_out[1], 32'h202);
    check_value("tp2_i3", inst_out[3], 32'h207);

    // Nine entries: full. A further group is dropped.
    step("tp3a", 8'h1F, 32'h300, 3'd0, 1'b0);
    check_value("tp3_full", 32'(full), 32'd1);
    step("tp3b", 8'hFF, 32'h400, 3'd0, 1'b0);
    check_value("tp3_cnt9", 32'(count), 32'd9);

    // Same-cycle dequeue of 4 and enqueue of 8.
    step("fl2", 8'h00, 32'h0, 3'd0, 1'b1);
    step("tp4a", 8'h3F, 32'h500, 3'd0, 1'b0);
    step("tp4b", 8'hFF, 32'h600, 3'd4, 1'b0);
    check_value("tp4_cnt", 32'(count), 32'd10);
    check_value("tp4_i0", inst_out[0], 32'h504);

    // Wrap-around: head and tail at 12, then enqueue a group that straddles the end.
    step("fl3", 8'h00, 32'h0, 3'd0, 1'b1);
    step("tp5a", 8'hFF, 32'h800, 3'd0, 1'b0);
    step("tp5b", 8'h0F, 32'h810, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step("tp5c", 8'h00, 32'h0, 3'd4, 1'b0);
    step("tp5d", 8'hFF, 32'h700, 3'd0, 1'b0);
    step("tp5e", 8'h00, 32'h0, 3'd4, 1'b0);
    check_value("tp5_i0", inst_out[0], 32'h704);
    step("tp5f", 8'h00, 32'h0, 3'd4, 1'b0);
    check_value("tp5_empty", 32'(empty), 32'd1);

    // A dequeue request above 4 removes only 4. Flush beats a same-cycle enqueue.
    step("tp6a", 8'h7F, 32'h900, 3'd0, 1'b0);
    step("tp6b", 8'h00, 32'h0, 3'd7, 1'b0);
    check_value("tp6_cnt3", 32'(count), 32'd3);
    step("tp6c", 8'hFF, 32'hA00, 3'd0, 1'b1);
    check_value("tp6_vld0", 32'(inst_vld[0]), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rnd", 8'($urandom), $urandom,
           ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)),
           $urandom_range(0, 31) == 0);
    end

    // Reset mid-operation clears state asynchronously.
    step("pre_rst", 8'hFF, 32'hB00, 3'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    model_q.delete(); model_ovf = 1'b0; model_drop = 0;
    check_outputs("midrst");
    check_value("midrst_i0", inst_out[0], 32'd0);
    #1 reset_n = 1'b1;
    lane_vld = 8'd0; retire_flush = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 100; i++) begin
      step("rnd2", 8'($urandom), $urandom, 3'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ace_instbuf.md
Name: ace_instbuf

Overview:
Instruction buffer at the fetch-to-decode boundary. It receives up to 8 fetched instructions per cycle (fetch D0 group, per-lane valid) and presents up to 4 oldest instructions in program order to the decode/rename slots. It returns back-pressure (instbuf_full_o) to fetch and is cleared by the retire flush. It is a circular FIFO with multi-entry enqueue and dequeue.

Parameters:
DEPTH, 16, number of 32-bit entries; power of 2, >= 16
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clock  input  1  core clock
reset_n  input  1  reset
retire_flush_i  input  1  flush; empties the buffer
fetch_inst0_i..fetch_inst7_i  input  32 each  fetched instructions, lane 0 oldest
fetch_inst0_vld_i..fetch_inst7_vld_i  input  1 each  lane valid; may be non-contiguous
deq_cnt_i  input  3  number of head entries decode consumes this cycle (0..4)
inst0_o..inst3_o  output  32 each  head entries, inst0_o oldest
inst0_vld_o..inst3_vld_o  output  1 each  slot k valid when count > k
instbuf_full_o  output  1  fewer than 8 free entries
instbuf_empty_o  output  1  count == 0
count_o  output  PTR_W+1  current occupancy

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: head_ptr=0, tail_ptr=0, count=0, storage=0. inst*_vld_o=0, inst*_o=0, instbuf_full_o=0, instbuf_empty_o=1, count_o=0.
- State is head_ptr, tail_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits) and the storage array.
- Outputs:
  - inst k out = storage[(head_ptr+k) mod DEPTH], combinational from registers.
  - inst k vld = (count > k).
  - instbuf_full_o = (count > DEPTH-8).
  - instbuf_empty_o = (count == 0).
  - All outputs depend on registered state only; no input-to-output paths.
- Enqueue:
  - Enabled when !instbuf_full_o && !retire_flush_i.
  - Valid lanes are compacted in lane order: the j-th valid lane (ascending lane index) writes storage[(tail_ptr+j) mod DEPTH].
  - n_enq = popcount of the valid bits; tail_ptr += n_enq.
  - Because full is computed from registered count, 8 free entries are guaranteed when enabled, independent of same-cycle dequeue.
- Enqueue while full: all lanes are dropped; no state change.
- Dequeue: n_deq = min(deq_cnt_i, 4, count); head_ptr += n_deq. deq_cnt_i values 5..7 are treated as 4.
- Same-cycle enqueue and dequeue: count_next = count + n_enq - n_deq. Entries written this cycle are visible on the outputs from the next cycle (1-cycle latency, no bypass).
- Flush: retire_flush_i=1 sets head_ptr=tail_ptr=0 and count=0 at the next edge. Flush overrides same-cycle enqueue and dequeue. Storage contents are not cleared.
- Wrap-around: pointers wrap naturally, and a compacted group may straddle index DEPTH-1 to 0.
- Reset mid-operation: returns immediately to the reset values above.

Optional Feature:
ACE_INSTBUF_OVF_EN
- Defined: adds output ovf_o (1 bit). It is a sticky flag set the cycle after any fetch lane is valid while instbuf_full_o=1 and retire_flush_i=0. Cleared by reset or retire_flush_i. Also adds output drop_cnt_o (16 bits), a saturating count of dropped instructions (popcount of valid lanes each drop cycle), cleared by reset only.
- Undefined: neither port exists; drops are silent.

Test Plan:
- Reset, then 8 lanes valid with values 0x100..0x107, deq_cnt_i=0 -> next cycle count_o=8, inst0..3_o=0x100..0x103, all vld=1, empty=0, full=0 (DEPTH=16, 8 > 8 is false).
- Valid mask 8'b1010_0101 with lane k value 0x200+k -> count_o=4, outputs 0x200, 0x202, 0x205, 0x207 in order.
- Fill to 9 entries -> full=1. Then present 8 valid lanes -> count stays 9, no write. With ACE_INSTBUF_OVF_EN, ovf_o=1 and drop_cnt_o=8.
- count=6, deq_cnt_i=4, 8 valid lanes same cycle -> count_o=10, inst0_o = old entry 4.
- Wrap: advance head and tail to 12, enqueue 8 -> entries occupy indices 12..15, 0..3. Dequeue 4 per cycle -> all 8 appear in order, then empty=1.
- count=7, deq_cnt_i=7 -> only 4 removed, count_o=3. Then retire_flush_i=1 with 8 valid lanes -> count_o=0, empty=1, all vld=0.
